// File: rtl/sad_pe_pkg.sv
// -----------------------------------------------------------------------------
// sad_pe_pkg
// Shared constants for the motion-estimation SAD processing-element array.
//   DWIDTH_DEFAULT : default pixel width in bits
//   SWIDTH_DEFAULT : default SAD accumulator width in bits
//   PE_ROW_GAP     : delay-line depth that chains rows of a 3-wide PE row
//                    scanning an 18-pixel search-window row (18 - 3 = 15)
// -----------------------------------------------------------------------------
package sad_pe_pkg;

  localparam int DWIDTH_DEFAULT = 8;
  localparam int SWIDTH_DEFAULT = 16;
  localparam int PE_ROW_GAP     = 15;

endpackage : sad_pe_pkg

// File: rtl/pel_delay_line.sv
// -----------------------------------------------------------------------------
// pel_delay_line
// Enable-gated pixel shift register. q is d delayed by DEPTH enabled cycles.
// While en is low every stage holds, so no data is lost. DEPTH = 0 makes the
// block a plain wire.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   en    : shift enable
//   d     : pixel in
//   q     : pixel out (last stage)
// -----------------------------------------------------------------------------
module pel_delay_line #(
  parameter int DEPTH  = 0,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire

    assign q = d;

    // Clock, reset and enable have no purpose without storage.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, en};

  end else begin : g_shift

    logic [DWIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset, not just the output stage, so nothing
    // unknown can ever shift out of the line after reset.
    // NOTE: non-blocking assignments make each stage take its neighbour's
    // pre-edge value; blocking would collapse the chain into one register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= '0;
        end
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign q = stage[DEPTH-1];

  end

endmodule : pel_delay_line

// File: rtl/sad_pe.sv
// -----------------------------------------------------------------------------
// sad_pe
// One processing element of the SAD array. Holds a search-window pixel in a
// pass-through register, accumulates |held SW pixel - broadcast TB pixel|
// into a saturating SAD, and optionally delays the SW pixel for row chaining.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous SAD clear (wins over en_tb)
//   en_sw      : advance SW register and delay line
//   en_tb      : accumulate this cycle
//   pel_sw     : incoming SW pixel
//   pel_tb     : broadcast TB pixel
//   nxt_sw     : registered SW pixel to the next PE
//   nxt_sw_dly : nxt_sw delayed by SR_DEPTH enabled cycles
//   sad        : accumulated SAD
// -----------------------------------------------------------------------------
module sad_pe
  import sad_pe_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEFAULT,
  parameter int SWIDTH   = SWIDTH_DEFAULT,
  parameter int SR_DEPTH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en_sw,
  input  logic              en_tb,
  input  logic [DWIDTH-1:0] pel_sw,
  input  logic [DWIDTH-1:0] pel_tb,
  output logic [DWIDTH-1:0] nxt_sw,
  output logic [DWIDTH-1:0] nxt_sw_dly,
  output logic [SWIDTH-1:0] sad
);

  localparam logic [SWIDTH-1:0] SAD_MAX = '1;

  logic [DWIDTH:0]   diff_wide;  // signed-style difference with borrow bit
  logic [DWIDTH-1:0] diff;       // absolute difference
  logic [SWIDTH:0]   sum;        // one carry bit for saturation detect
  logic [SWIDTH-1:0] sad_next;

  // SW pass-through register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_sw <= '0;
    end else if (en_sw) begin
      nxt_sw <= pel_sw;
    end
  end

  // Difference uses the register's current value, so a simultaneous en_sw
  // accumulates the pixel that was held before this edge.
  assign diff_wide = {1'b0, nxt_sw} - {1'b0, pel_tb};

  // NOTE: sad_next gets a default before any branch so the block can never
  // infer a latch, whatever branches are added later.
  always_comb begin
    diff     = diff_wide[DWIDTH-1:0];
    sum      = '0;
    sad_next = sad;
    if (diff_wide[DWIDTH]) begin
      diff = DWIDTH'(-diff_wide);  // borrow set: pel_tb was larger
    end
    sum = {1'b0, sad} + (SWIDTH+1)'(diff);
    if (clr) begin
      sad_next = '0;
    end else if (en_tb) begin
      sad_next = sum[SWIDTH] ? SAD_MAX : sum[SWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad <= '0;
    end else begin
      sad <= sad_next;
    end
  end

  pel_delay_line #(
    .DEPTH  (SR_DEPTH),
    .DWIDTH (DWIDTH)
  ) u_row_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_sw),
    .d     (nxt_sw),
    .q     (nxt_sw_dly)
  );

endmodule : sad_pe

// File: tb/tb_sad_pe.sv
// -----------------------------------------------------------------------------
// tb_sad_pe
// Directed testbench for sad_pe with the row-wrap delay line enabled
// (SR_DEPTH = PE_ROW_GAP = 15). Inputs change 1 time unit after the rising
// edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sad_pe;
  import sad_pe_pkg::*;

  localparam int DW = DWIDTH_DEFAULT;
  localparam int SW = SWIDTH_DEFAULT;
  localparam int SR = PE_ROW_GAP;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          en_sw;
  logic          en_tb;
  logic [DW-1:0] pel_sw;
  logic [DW-1:0] pel_tb;
  logic [DW-1:0] nxt_sw;
  logic [DW-1:0] nxt_sw_dly;
  logic [SW-1:0] sad;

  int checks   = 0;
  int failures = 0;

  sad_pe #(
    .DWIDTH   (DW),
    .SWIDTH   (SW),
    .SR_DEPTH (SR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en_sw      (en_sw),
    .en_tb      (en_tb),
    .pel_sw     (pel_sw),
    .pel_tb     (pel_tb),
    .nxt_sw     (nxt_sw),
    .nxt_sw_dly (nxt_sw_dly),
    .sad        (sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load the SW register without accumulating.
  task automatic load_sw(input logic [DW-1:0] v);
    en_sw  = 1'b1;
    en_tb  = 1'b0;
    pel_sw = v;
    step();
    en_sw  = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    en_sw  = 1'b0;
    en_tb  = 1'b0;
    pel_sw = '0;
    pel_tb = '0;
    step();
    step();

    // ---------------- reset state ----------------
    check("rst_sad", int'(sad), 0);
    check("rst_nxt_sw", int'(nxt_sw), 0);
    check("rst_dly", int'(nxt_sw_dly), 0);
    rst_n = 1'b1;
    step();

    // ---------------- pass-through ----------------
    en_sw = 1'b1;
    pel_sw = 8'd10; step(); check("pass_10", int'(nxt_sw), 10);
    pel_sw = 8'd20; step(); check("pass_20", int'(nxt_sw), 20);
    pel_sw = 8'd30; step(); check("pass_30", int'(nxt_sw), 30);
    en_sw = 1'b0;
    pel_sw = 8'd99;
    step(); check("hold_1", int'(nxt_sw), 30);
    step(); check("hold_2", int'(nxt_sw), 30);
    check("no_acc_sad", int'(sad), 0);

    // ---------------- accumulate ----------------
    load_sw(8'd200);
    en_tb = 1'b1; pel_tb = 8'd50;
    step(); check("acc_150", int'(sad), 150);
    step(); check("acc_300", int'(sad), 300);
    step(); check("acc_450", int'(sad), 450);
    load_sw(8'd50);
    check("acc_hold", int'(sad), 450);
    en_tb = 1'b1; pel_tb = 8'd200;
    step(); check("acc_abs_600", int'(sad), 600);

    // ---------------- clear priority ----------------
    clr = 1'b1; en_tb = 1'b1;
    step(); check("clr_prio", int'(sad), 0);
    check("clr_keeps_sw", int'(nxt_sw), 50);
    clr = 1'b0;
    step(); check("clr_restart", int'(sad), 150);

    // Simultaneous en_sw/en_tb: old pixel 50 accumulated, then new pixel 0.
    en_sw = 1'b1; pel_sw = 8'd0;
    step(); check("simul_old_pix", int'(sad), 300);
    check("simul_new_sw", int'(nxt_sw), 0);
    en_sw = 1'b0;
    step(); check("simul_next", int'(sad), 500);
    en_tb = 1'b0;
    step(); check("en_tb_low_hold", int'(sad), 500);

    // ---------------- full block and saturation ----------------
    clr = 1'b1; step(); clr = 1'b0;
    load_sw(8'd255);
    en_tb = 1'b1; pel_tb = 8'd0;
    for (int i = 0; i < 256; i++) step();
    check("full_block", int'(sad), 65280);
    load_sw(8'd220);
    en_tb = 1'b1;
    step(); check("preload_65500", int'(sad), 65500);
    load_sw(8'd255);
    en_tb = 1'b1;
    step(); check("sat_max", int'(sad), 65535);
    step(); check("sat_stay", int'(sad), 65535);
    en_tb = 1'b0;

    // ---------------- delay line ----------------
    en_sw = 1'b1; pel_sw = 8'd0;
    for (int i = 0; i < SR + 1; i++) step();
    pel_sw = 8'hAB;
    step();                                   // enabled cycle 1
    pel_sw = 8'd0;
    check("dly_nxt_sw", int'(nxt_sw), 'hAB);
    check("dly_not_yet_1", int'(nxt_sw_dly), 0);
    for (int i = 2; i <= SR; i++) step();     // enabled cycles 2..15
    check("dly_not_yet_15", int'(nxt_sw_dly), 0);
    step();                                   // enabled cycle 16
    check("dly_16", int'(nxt_sw_dly), 'hAB);
    step();
    check("dly_passed", int'(nxt_sw_dly), 0);

    // Same pulse with a 3-cycle en_sw gap after enabled cycle 5.
    for (int i = 0; i < SR + 1; i++) step();
    pel_sw = 8'hAB;
    step();
    pel_sw = 8'd0;
    for (int i = 2; i <= 5; i++) step();
    en_sw = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("gap_freeze_sw", int'(nxt_sw), 0);
    check("gap_freeze_dly", int'(nxt_sw_dly), 0);
    en_sw = 1'b1;
    for (int i = 6; i <= SR; i++) step();     // edge 18 overall
    check("gap_not_yet", int'(nxt_sw_dly), 0);
    step();                                   // edge 19 = 16 enabled
    check("gap_dly_16", int'(nxt_sw_dly), 'hAB);
    en_sw = 1'b0;

    // ---------------- async reset mid-run ----------------
    clr = 1'b1; en_sw = 1'b1; pel_sw = 8'h55;
    for (int i = 0; i < SR + 1; i++) step();
    clr = 1'b0; en_sw = 1'b0; en_tb = 1'b1;
    pel_tb = 8'd255; step();                  // |85-255| = 170
    pel_tb = 8'd206; step();                  // |85-206| = 121 -> 291
    check("pre_rst_sad", int'(sad), 'h0123);
    check("pre_rst_sw", int'(nxt_sw), 'h55);
    check("pre_rst_dly", int'(nxt_sw_dly), 'h55);
    pel_tb = 8'd7;
    #2;
    rst_n = 1'b0;
    #1;                                       // still before the next edge
    check("async_rst_sad", int'(sad), 0);
    check("async_rst_sw", int'(nxt_sw), 0);
    check("async_rst_dly", int'(nxt_sw_dly), 0);
    step();
    check("rst_held_sad", int'(sad), 0);
    rst_n = 1'b1;
    step(); check("resume_sad", int'(sad), 7);
    en_tb = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sad_pe
